// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: selects a fast or slow divider tap, or produces one
// fixed-width pulse per debounced button press. Mode switches only happen
// while the CPU clock is low, so no runt pulses reach the CPU. Also emits a
// one-cycle clock enable per CPU rising edge and a free-running edge count.
module cpu_clk_ctrl #(
  parameter int DB_TICK_BIT = 17,
  parameter int DB_CNT      = 4,
  parameter int FAST_BIT    = 2,
  parameter int SLOW_BIT    = 24,
  parameter int STEP_HIGH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        SW2,
  input  logic        SW_step,
  input  logic        BTN_step,
  output logic        Clk_CPU,
  output logic        cpu_ce,
  output logic        btn_db,
  output logic [15:0] step_cnt
);

  localparam int DB_W = $clog2(DB_CNT) + 1;
  localparam int HI_W = $clog2(STEP_HIGH) + 1;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DB_CNT);
  localparam logic [HI_W-1:0] HI_LOAD = HI_W'(STEP_HIGH - 1);

  typedef enum logic [1:0] {M_FAST, M_SLOW, M_STEP} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_WAIT} state_e;

  logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic            tick_prev_q, tick_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic            btn_db_q, btn_db_d, btn_db_dly_q, btn_db_dly_d;
  logic            tick, btn_rise;

  mode_e           mode_q, mode_d, req_mode;
  logic            mode_chg;
  state_e          state_q, state_d;
  logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
  logic            clk_cpu_q, clk_cpu_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic [15:0]     step_cnt_q, step_cnt_d;

  // Only a few divider taps are used; fold the rest into a named sink.
  logic unused_clkdiv;
  assign unused_clkdiv = ^clkdiv;

  assign tick     = clkdiv[DB_TICK_BIT] & ~tick_prev_q;
  assign db_inc   = db_cnt_q + 1'b1;
  assign btn_rise = btn_db_q & ~btn_db_dly_q;

  // Button synchroniser, debounce-tick edge detect and debounce counter.
  always_comb begin
    btn_s1_d     = BTN_step;
    btn_s2_d     = btn_s1_q;
    tick_prev_d  = clkdiv[DB_TICK_BIT];
    btn_db_dly_d = btn_db_q;
    db_cnt_d     = db_cnt_q;
    btn_db_d     = btn_db_q;
    if (tick) begin
      if (btn_s2_q == btn_db_q) begin
        db_cnt_d = '0;
      end else if (db_inc == DB_MAX) begin
        btn_db_d = ~btn_db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_inc;
      end
    end
  end

  // Mode arbitration, step FSM and CPU clock / enable / edge-count next state.
  always_comb begin
    req_mode  = SW_step ? M_STEP : (SW2 ? M_SLOW : M_FAST);
    mode_chg  = !clk_cpu_q && (req_mode != mode_q);
    mode_d    = mode_chg ? req_mode : mode_q;
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    clk_cpu_d = 1'b0;
    case (mode_q)
      M_FAST: begin
        clk_cpu_d = clkdiv[FAST_BIT];
        state_d   = S_IDLE;
      end
      M_SLOW: begin
        clk_cpu_d = clkdiv[SLOW_BIT];
        state_d   = S_IDLE;
      end
      default: begin
        case (state_q)
          S_IDLE: begin
            // A pulse is not started in the cycle we are leaving step mode,
            // otherwise the next mode would truncate it.
            if (btn_rise && !mode_chg) begin
              state_d   = S_HIGH;
              hi_cnt_d  = HI_LOAD;
              clk_cpu_d = 1'b1;
            end
          end
          S_HIGH: begin
            if (hi_cnt_q == '0) begin
              state_d = S_WAIT;
            end else begin
              hi_cnt_d  = hi_cnt_q - 1'b1;
              clk_cpu_d = 1'b1;
            end
          end
          S_WAIT: begin
            if (!btn_db_q || mode_chg) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    endcase
    cpu_ce_d   = clk_cpu_d & ~clk_cpu_q;
    step_cnt_d = step_cnt_q + 16'(cpu_ce_d);
  end

  // Debounce path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      tick_prev_q  <= 1'b0;
      db_cnt_q     <= '0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
    end else begin
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      tick_prev_q  <= tick_prev_d;
      db_cnt_q     <= db_cnt_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
    end
  end

  // Mode, step FSM and CPU clock output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= M_FAST;
      state_q    <= S_IDLE;
      hi_cnt_q   <= '0;
      clk_cpu_q  <= 1'b0;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      clk_cpu_q  <= clk_cpu_d;
      cpu_ce_q   <= cpu_ce_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign Clk_CPU  = clk_cpu_q;
  assign cpu_ce   = cpu_ce_q;
  assign btn_db   = btn_db_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: vector table for run modes and reset
// recovery, hand-written sequences for debounce, single-step and wrap.
module tb_cpu_clk_ctrl;

  logic        clk, rst;
  logic [31:0] clkdiv;
  logic        SW2, SW_step, BTN_step;
  logic        Clk_CPU, cpu_ce, btn_db;
  logic [15:0] step_cnt;
  logic        clk_cpu2, cpu_ce2, btn_db2;
  logic [15:0] step_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int hi1 = 0, ce1 = 0, hi2 = 0, ce2 = 0;
  int hb, cb, h2b, c2b;

  typedef struct packed {
    logic [31:0] cd;
    logic        sw2;
    logic        sws;
    logic        eclk;
    logic        ece;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt [48];
  int   nv = 0;

  cpu_clk_ctrl dut (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .SW2(SW2), .SW_step(SW_step),
    .BTN_step(BTN_step), .Clk_CPU(Clk_CPU), .cpu_ce(cpu_ce), .btn_db(btn_db),
    .step_cnt(step_cnt)
  );

  cpu_clk_ctrl #(.DB_CNT(1), .STEP_HIGH(10)) dut2 (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .SW2(SW2), .SW_step(SW_step),
    .BTN_step(BTN_step), .Clk_CPU(clk_cpu2), .cpu_ce(cpu_ce2), .btn_db(btn_db2),
    .step_cnt(step_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Clk_CPU)  hi1 <= hi1 + 1;
    if (cpu_ce)   ce1 <= ce1 + 1;
    if (clk_cpu2) hi2 <= hi2 + 1;
    if (cpu_ce2)  ce2 <= ce2 + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] cd, input logic s2, input logic ss,
                     input logic ec, input logic ee, input logic [15:0] en);
    vt[nv] = {cd, s2, ss, ec, ee, en};
    nv++;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      clkdiv  = vt[i].cd;
      SW2     = vt[i].sw2;
      SW_step = vt[i].sws;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d Clk_CPU", i), 32'(Clk_CPU), 32'(vt[i].eclk));
      chk($sformatf("row%0d cpu_ce", i), 32'(cpu_ce), 32'(vt[i].ece));
      chk($sformatf("row%0d step_cnt", i), 32'(step_cnt), 32'(vt[i].ecnt));
    end
  endtask

  // Present a button level, let it cross the synchroniser, then one tick.
  task automatic do_tick(input logic b);
    @(negedge clk); BTN_step = b;
    @(negedge clk);
    @(negedge clk); clkdiv[17] = 1'b1;
    @(negedge clk); clkdiv[17] = 1'b0;
  endtask

  task automatic reset_into(input logic step_mode);
    @(negedge clk);
    rst = 1'b0; BTN_step = 1'b0; SW2 = 1'b0; SW_step = step_mode; clkdiv = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic pat [7];

  initial begin
    // fast run from clkdiv = 0 (idx 0..15)
    add(32'd0, 0, 0, 0, 0, 16'd0);  add(32'd1, 0, 0, 0, 0, 16'd0);
    add(32'd2, 0, 0, 0, 0, 16'd0);  add(32'd3, 0, 0, 0, 0, 16'd0);
    add(32'd4, 0, 0, 1, 1, 16'd1);  add(32'd5, 0, 0, 1, 0, 16'd1);
    add(32'd6, 0, 0, 1, 0, 16'd1);  add(32'd7, 0, 0, 1, 0, 16'd1);
    add(32'd8, 0, 0, 0, 0, 16'd1);  add(32'd9, 0, 0, 0, 0, 16'd1);
    add(32'd10, 0, 0, 0, 0, 16'd1); add(32'd11, 0, 0, 0, 0, 16'd1);
    add(32'd12, 0, 0, 1, 1, 16'd2); add(32'd13, 0, 0, 1, 0, 16'd2);
    add(32'd14, 0, 0, 1, 0, 16'd2); add(32'd15, 0, 0, 1, 0, 16'd2);
    // fast -> slow requested while Clk_CPU high (idx 16..36)
    add(32'd32, 0, 0, 0, 0, 16'd4); add(32'd33, 0, 0, 0, 0, 16'd4);
    add(32'd34, 0, 0, 0, 0, 16'd4); add(32'd35, 0, 0, 0, 0, 16'd4);
    add(32'd36, 0, 0, 1, 1, 16'd5); add(32'd37, 1, 0, 1, 0, 16'd5);
    add(32'd38, 1, 0, 1, 0, 16'd5); add(32'd39, 1, 0, 1, 0, 16'd5);
    add(32'd40, 1, 0, 0, 0, 16'd5); add(32'd41, 1, 0, 0, 0, 16'd5);
    add(32'd42, 1, 0, 0, 0, 16'd5); add(32'd43, 1, 0, 0, 0, 16'd5);
    add(32'd44, 1, 0, 0, 0, 16'd5); add(32'd45, 1, 0, 0, 0, 16'd5);
    add(32'd46, 1, 0, 0, 0, 16'd5); add(32'd47, 1, 0, 0, 0, 16'd5);
    add(32'h0100_0000, 1, 0, 1, 1, 16'd6); add(32'h0100_0001, 1, 0, 1, 0, 16'd6);
    add(32'h0100_0002, 1, 0, 1, 0, 16'd6); add(32'h0100_0003, 1, 0, 1, 0, 16'd6);
    add(32'h0000_0004, 1, 0, 0, 0, 16'd6);
    // after mid-pulse reset: fast mode, no enable on release (idx 37..41)
    add(32'd0, 0, 0, 0, 0, 16'd0);  add(32'd0, 0, 0, 0, 0, 16'd0);
    add(32'd4, 0, 0, 1, 1, 16'd1);  add(32'd5, 0, 0, 1, 0, 16'd1);
    add(32'd0, 0, 0, 0, 0, 16'd1);
    // edge counter wrap from 0xFFFE (idx 42..44)
    add(32'd4, 0, 0, 1, 1, 16'hFFFF); add(32'd0, 0, 0, 0, 0, 16'hFFFF);
    add(32'd4, 0, 0, 1, 1, 16'h0000);

    clkdiv = '0; SW2 = 1'b0; SW_step = 1'b0; BTN_step = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset Clk_CPU", 32'(Clk_CPU), 32'd0);
    chk("reset cpu_ce", 32'(cpu_ce), 32'd0);
    chk("reset btn_db", 32'(btn_db), 32'd0);
    chk("reset step_cnt", 32'(step_cnt), 32'd0);
    rst = 1'b1;

    run_rows(0, 15);
    for (int c = 16; c < 32; c++) begin
      @(negedge clk);
      clkdiv = c;
    end
    @(posedge clk);
    #1;
    chk("fast 32clk step_cnt", 32'(step_cnt), 32'd4);
    chk("fast 32clk Clk_CPU", 32'(Clk_CPU), 32'd1);
    run_rows(16, 36);

    // single step with bouncy press, then held
    reset_into(1'b1);
    #2; hb = hi1; cb = ce1;
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      do_tick(pat[k]);
      chk($sformatf("debounce tick%0d btn_db", k), 32'(btn_db), (k == 6) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 6; k++) do_tick(1'b1);
    #2;
    chk("step1 high clks", 32'(hi1 - hb), 32'd4);
    chk("step1 ce pulses", 32'(ce1 - cb), 32'd1);
    chk("step1 step_cnt", 32'(step_cnt), 32'd1);
    chk("step1 held btn_db", 32'(btn_db), 32'd1);

    // release and second press
    hb = hi1; cb = ce1;
    for (int k = 0; k < 4; k++) do_tick(1'b0);
    chk("release btn_db", 32'(btn_db), 32'd0);
    for (int k = 0; k < 4; k++) do_tick(1'b1);
    chk("press2 btn_db", 32'(btn_db), 32'd1);
    repeat (8) @(negedge clk);
    #2;
    chk("step2 high clks", 32'(hi1 - hb), 32'd4);
    chk("step2 ce pulses", 32'(ce1 - cb), 32'd1);
    chk("step2 step_cnt", 32'(step_cnt), 32'd2);

    // short-debounce instance: second rise lands inside the high phase
    reset_into(1'b1);
    #2; h2b = hi2; c2b = ce2;
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b1);
    repeat (12) @(negedge clk);
    #2;
    chk("rise in HIGH high clks", 32'(hi2 - h2b), 32'd10);
    chk("rise in HIGH ce pulses", 32'(ce2 - c2b), 32'd1);
    chk("rise in HIGH step_cnt", 32'(step_cnt2), 32'd1);
    chk("rise in HIGH btn_db", 32'(btn_db2), 32'd1);

    // reset asserted in the middle of a step pulse
    reset_into(1'b1);
    for (int k = 0; k < 4; k++) do_tick(1'b1);
    @(negedge clk);
    chk("pre-reset Clk_CPU", 32'(Clk_CPU), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid-pulse reset Clk_CPU", 32'(Clk_CPU), 32'd0);
    chk("mid-pulse reset step_cnt", 32'(step_cnt), 32'd0);
    chk("mid-pulse reset cpu_ce", 32'(cpu_ce), 32'd0);
    chk("mid-pulse reset btn_db", 32'(btn_db), 32'd0);
    SW_step = 1'b0; BTN_step = 1'b0; clkdiv = '0;
    @(negedge clk);
    rst = 1'b1;
    run_rows(37, 41);

    // wrap of the edge counter
    @(negedge clk);
    force dut.step_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.step_cnt_q;
    #1;
    chk("preload step_cnt", 32'(step_cnt), 32'hFFFE);
    run_rows(42, 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Sits directly downstream of the free-running divider and consumes its clkdiv[31:0] bus.
- Produces the CPU clock with three modes: fast run, slow run, and single-step from a debounced push button.
- Mode changes are glitch-free, and the block emits a one-cycle clock-enable and a CPU edge counter for the display logic.

Parameters:
- DB_TICK_BIT, 17: clkdiv bit whose rising edge is the debounce sample tick.
- DB_CNT, 4: number of consecutive differing samples needed to flip the debounced button.
- FAST_BIT, 2: clkdiv bit used as the fast-run CPU clock.
- SLOW_BIT, 24: clkdiv bit used as the slow-run CPU clock.
- STEP_HIGH, 4: number of clk cycles Clk_CPU stays high per single step (must be ≥1).

Ports:
- clk  in  1  system clock, same clock that drives clkdiv.
- rst  in  1  asynchronous, active-low reset.
- clkdiv  in  32  free-running divider count.
- SW2  in  1  run-speed select: 1 = slow, 0 = fast.
- SW_step  in  1  1 = single-step mode; overrides SW2.
- BTN_step  in  1  raw, asynchronous, bouncy step button (active-high).
- Clk_CPU  out  1  registered CPU clock.
- cpu_ce  out  1  one-clk pulse coincident with each Clk_CPU rising edge.
- btn_db  out  1  debounced button level.
- step_cnt  out  16  count of Clk_CPU rising edges since reset.

Behaviour:
- Reset (rst=0, async): every register is cleared.
  - Clk_CPU=0, cpu_ce=0, btn_db=0, step_cnt=0.
  - Debounce counter=0, both sync flops=0, tick history=0.
  - Active mode = FAST, step FSM = S_IDLE.
- Button sync: BTN_step passes through 2 flops before any use.
- Tick: tick = clkdiv[DB_TICK_BIT] & ~prev, where prev is that bit registered. tick is exactly one clk wide.
- Debounce, evaluated only on tick:
  - If the synced sample equals btn_db, clear the counter.
  - Otherwise increment the counter. When the incremented value equals DB_CNT, toggle btn_db and clear the counter.
  - Counter width is clog2(DB_CNT)+1.
- btn_rise = btn_db & ~btn_db_d, where btn_db_d is btn_db delayed one clk.
- Requested mode: SW_step ? STEP : (SW2 ? SLOW : FAST).
- Mode update: the active mode loads the requested mode only in a cycle where Clk_CPU=0 and the two differ. The new mode drives Clk_CPU from the next cycle.
- FAST / SLOW modes:
  - Clk_CPU <= clkdiv[FAST_BIT] or clkdiv[SLOW_BIT], i.e. one clk of latency.
  - Step FSM is forced to S_IDLE.
- STEP mode, step FSM:
  - S_IDLE: Clk_CPU <= 0. On btn_rise: go to S_HIGH, load the high counter with STEP_HIGH-1, Clk_CPU <= 1.
  - S_HIGH: Clk_CPU held at 1. Decrement the high counter. When it reaches 0: Clk_CPU <= 0 and go to S_WAIT.
  - S_WAIT: Clk_CPU=0. When btn_db=0, go to S_IDLE.
  - Result: exactly one pulse per press, and a held button gives no repeat.
- Leaving STEP mode:
  - Cannot happen while Clk_CPU=1, so S_HIGH always completes its full width first.
  - From S_WAIT, the FSM returns to S_IDLE.
- cpu_ce: registered alongside Clk_CPU. It is 1 for the single clk in which Clk_CPU goes 0→1, and 0 otherwise.
- step_cnt: increments in the same cycle cpu_ce=1. Wraps from 0xFFFF to 0x0000.
- Simultaneous events:
  - A tick in the same cycle as a mode change: both take effect independently.
  - btn_rise while in S_HIGH or S_WAIT: ignored.
- Reset mid-pulse: Clk_CPU drops to 0 immediately (asynchronously). No cpu_ce is produced on reset release.

Test Plan:
- FAST mode, SW2=0, SW_step=0, clkdiv counting from 0 → Clk_CPU copies clkdiv[2] one clk late. cpu_ce period is 8 clk. step_cnt=4 after 32 clk.
- Mode change fast→slow asserted while Clk_CPU=1 → no change until Clk_CPU falls. Then Clk_CPU follows clkdiv[24]. No high pulse shorter than 4 clk.
- STEP mode, BTN_step bounces 0/1 for 3 ticks then holds 1 for 10 ticks → btn_db rises exactly once, after the 4th stable tick. Clk_CPU is high for exactly 4 clk. step_cnt=1. No second pulse while held.
- STEP mode, release and second press → second 4-clk pulse, step_cnt=2. Press during S_HIGH (forced via short debounce) → ignored.
- Reset asserted during S_HIGH → Clk_CPU=0 and step_cnt=0 immediately. After release: mode FAST, FSM S_IDLE.
- step_cnt preloaded via forced run to 0xFFFF, one more rising edge → 0x0000 and cpu_ce=1 in that cycle.
